// File: rtl/lcd_scaled_timing_gen.sv
// lcd_scaled_timing_gen: parametrised LCD sync/DE generator with DDA-scaled framebuffer fetch.
// Optional colour-bar test pattern when LCD_TESTPAT_EN is defined (adds pat_sel input).
module lcd_scaled_timing_gen #(
    parameter int H_AREA  = 800,
    parameter int H_PULSE = 1,
    parameter int H_BP    = 46,
    parameter int H_FP    = 210,
    parameter int V_AREA  = 480,
    parameter int V_PULSE = 4,
    parameter int V_BP    = 20,
    parameter int V_FP    = 19,
    parameter int IMG_W   = 200,
    parameter int IMG_H   = 138,
    parameter int ADDR_W  = 15,
    parameter int MEM_LAT = 1
) (
    input  logic              PixelClk,
    input  logic              RST,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [15:0]       mem_data,
`ifdef LCD_TESTPAT_EN
    input  logic              pat_sel,
`endif
    output logic              frame_start,
    output logic              LCD_DE,
    output logic              LCD_HSYNC,
    output logic              LCD_VSYNC,
    output logic [4:0]        LCD_R,
    output logic [5:0]        LCD_G,
    output logic [4:0]        LCD_B
);
    localparam int H_TOT = H_PULSE + H_BP + H_AREA + H_FP;
    localparam int V_TOT = V_PULSE + V_BP + V_AREA + V_FP;
    localparam int L     = MEM_LAT + 1;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int XAW   = $clog2(2 * H_AREA) + 1;
    localparam int YAW   = $clog2(2 * V_AREA) + 1;

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
    localparam logic [HW-1:0] HP_END  = HW'(H_PULSE);
    localparam logic [HW-1:0] HA_BEG  = HW'(H_PULSE + H_BP);
    localparam logic [HW-1:0] HA_LAST = HW'(H_PULSE + H_BP + H_AREA - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
    localparam logic [VW-1:0] VP_END  = VW'(V_PULSE);
    localparam logic [VW-1:0] VA_BEG  = VW'(V_PULSE + V_BP);
    localparam logic [VW-1:0] VA_LAST = VW'(V_PULSE + V_BP + V_AREA - 1);

    logic [HW-1:0]     pcnt;
    logic [VW-1:0]     lcnt;
    logic              h_act, v_act, de_raw, hs_raw, vs_raw, fs_raw;
    logic [XAW-1:0]    xacc, x_sum;
    logic [YAW-1:0]    yacc, y_sum;
    logic              x_step, y_step;
    logic [ADDR_W-1:0] img_x, img_y, line_base;
    logic [L-1:0]      de_sr, hs_sr, vs_sr, fs_sr;
    logic              pat_now;
    logic [15:0]       px;

    assign h_act  = pcnt >= HA_BEG && pcnt <= HA_LAST;
    assign v_act  = lcnt >= VA_BEG && lcnt <= VA_LAST;
    assign de_raw = h_act && v_act;
    assign hs_raw = pcnt >= HP_END;
    assign vs_raw = lcnt >= VP_END;
    assign fs_raw = pcnt == HA_BEG && lcnt == VA_BEG;

    always_ff @(posedge PixelClk) begin
        if (RST) begin
            pcnt <= '0;
            lcnt <= '0;
        end else begin
            pcnt <= pcnt == H_LAST ? '0 : pcnt + 1'b1;
            if (pcnt == H_LAST)
                lcnt <= lcnt == V_LAST ? '0 : lcnt + 1'b1;
        end
    end

    // img_x always holds floor(dx*IMG_W/H_AREA) for the pixel currently at pcnt
    assign x_sum  = xacc + XAW'(IMG_W);
    assign x_step = x_sum >= XAW'(H_AREA);

    always_ff @(posedge PixelClk) begin
        if (RST || !h_act || pcnt == HA_LAST) begin
            xacc  <= '0;
            img_x <= '0;
        end else begin
            xacc  <= x_step ? x_sum - XAW'(H_AREA) : x_sum;
            img_x <= img_x + ADDR_W'(x_step);
        end
    end

    assign y_sum  = yacc + YAW'(IMG_H);
    assign y_step = y_sum >= YAW'(V_AREA);

    always_ff @(posedge PixelClk) begin
        if (RST || !v_act || (pcnt == H_LAST && lcnt == VA_LAST)) begin
            yacc      <= '0;
            img_y     <= '0;
            line_base <= '0;
        end else if (pcnt == H_LAST) begin
            yacc      <= y_step ? y_sum - YAW'(V_AREA) : y_sum;
            img_y     <= img_y + ADDR_W'(y_step);
            line_base <= y_step ? line_base + ADDR_W'(IMG_W) : line_base;
        end
    end

    always_ff @(posedge PixelClk) begin
        if (RST) begin
            mem_addr <= '0;
            mem_rd   <= 1'b0;
            de_sr    <= '0;
            hs_sr    <= '1;
            vs_sr    <= '1;
            fs_sr    <= '0;
        end else begin
            mem_addr <= de_raw ? line_base + img_x : '0;
            mem_rd   <= de_raw && !pat_now;
            de_sr    <= {de_sr[L-2:0], de_raw};
            hs_sr    <= {hs_sr[L-2:0], hs_raw};
            vs_sr    <= {vs_sr[L-2:0], vs_raw};
            fs_sr    <= {fs_sr[L-2:0], fs_raw};
        end
    end

`ifdef LCD_TESTPAT_EN
    localparam int BAR_W = H_AREA / 8;
    localparam int BW    = $clog2(BAR_W + 1);
    localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    logic          pat_en;
    logic [BW-1:0] bar_cnt;
    logic [2:0]    bar;
    logic [L-1:0]  pat_sr;
    logic [2:0]    bar_sr [L];

    // pat_sel takes effect on the very pixel that starts the frame
    assign pat_now = fs_raw ? pat_sel : pat_en;

    always_ff @(posedge PixelClk) begin
        if (RST) begin
            pat_en  <= 1'b0;
            bar_cnt <= '0;
            bar     <= '0;
            pat_sr  <= '0;
            for (int i = 0; i < L; i++) bar_sr[i] <= '0;
        end else begin
            if (fs_raw) pat_en <= pat_sel;
            bar_cnt <= (!h_act || bar_cnt == BW'(BAR_W - 1)) ? '0 : bar_cnt + 1'b1;
            bar     <= !h_act ? '0 : (bar_cnt == BW'(BAR_W - 1) && bar != 3'd7) ? bar + 1'b1 : bar;
            pat_sr  <= {pat_sr[L-2:0], pat_now};
            bar_sr[0] <= bar;
            for (int i = 1; i < L; i++) bar_sr[i] <= bar_sr[i-1];
        end
    end

    assign px = pat_sr[L-1] ? BARS[bar_sr[L-1]] : mem_data;
`else
    assign pat_now = 1'b0;
    assign px      = mem_data;
`endif

    assign LCD_DE      = de_sr[L-1];
    assign LCD_HSYNC   = hs_sr[L-1];
    assign LCD_VSYNC   = vs_sr[L-1];
    assign frame_start = fs_sr[L-1];
    assign {LCD_R, LCD_G, LCD_B} = LCD_DE ? px : 16'h0000;

    a_img_x: assert property (@(posedge PixelClk) disable iff (RST) img_x <= ADDR_W'(IMG_W - 1));
    a_img_y: assert property (@(posedge PixelClk) disable iff (RST) img_y <= ADDR_W'(IMG_H - 1));
endmodule

// File: tb/tb_lcd_scaled_timing_gen.sv
// tb_lcd_scaled_timing_gen: two instances (read latency 1 and 3) on a small geometry,
// every cycle compared against an arithmetic model of counters, syncs and scaled addresses.
module tb_lcd_scaled_timing_gen;
    localparam int HP = 2, HB = 3, HA = 16, HF = 4;
    localparam int VP = 2, VB = 2, VA = 12, VF = 3;
    localparam int IW = 5, IH = 7, AW = 6;
    localparam int HT = HP + HB + HA + HF;
    localparam int VT = VP + VB + VA + VF;
    localparam int FR = HT * VT;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] mem [64];
    logic [AW-1:0] a_addr, b_addr;
    logic a_rd, b_rd, a_fs, b_fs, a_de, b_de, a_hs, b_hs, a_vs, b_vs;
    logic [4:0] a_r, b_r, a_b, b_b;
    logic [5:0] a_g, b_g;
    logic [15:0] qa, a_data, b_data;
    logic [15:0] qb [3];

    lcd_scaled_timing_gen #(.H_AREA(HA), .H_PULSE(HP), .H_BP(HB), .H_FP(HF),
        .V_AREA(VA), .V_PULSE(VP), .V_BP(VB), .V_FP(VF), .IMG_W(IW), .IMG_H(IH),
        .ADDR_W(AW), .MEM_LAT(1)) dut_a (
        .PixelClk(clk), .RST(rst), .mem_addr(a_addr), .mem_rd(a_rd), .mem_data(a_data),
        .frame_start(a_fs), .LCD_DE(a_de), .LCD_HSYNC(a_hs), .LCD_VSYNC(a_vs),
        .LCD_R(a_r), .LCD_G(a_g), .LCD_B(a_b));

    lcd_scaled_timing_gen #(.H_AREA(HA), .H_PULSE(HP), .H_BP(HB), .H_FP(HF),
        .V_AREA(VA), .V_PULSE(VP), .V_BP(VB), .V_FP(VF), .IMG_W(IW), .IMG_H(IH),
        .ADDR_W(AW), .MEM_LAT(3)) dut_b (
        .PixelClk(clk), .RST(rst), .mem_addr(b_addr), .mem_rd(b_rd), .mem_data(b_data),
        .frame_start(b_fs), .LCD_DE(b_de), .LCD_HSYNC(b_hs), .LCD_VSYNC(b_vs),
        .LCD_R(b_r), .LCD_G(b_g), .LCD_B(b_b));

    // Framebuffer stand-ins with 1 and 3 cycle read latency
    always @(posedge clk) begin
        qa    <= mem[a_addr];
        qb[0] <= mem[b_addr];
        qb[1] <= qb[0];
        qb[2] <= qb[1];
    end
    assign a_data = qa;
    assign b_data = qb[2];

    int cyc = 0;
    bit valid = 0;
    int n_chk = 0, n_err = 0;

    always @(posedge clk) begin
        if (rst) begin
            cyc   <= 0;
            valid <= 1;
        end else begin
            cyc <= cyc + 1;
        end
    end

    task automatic check(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    function automatic int f_de(int k);
        int p = k % HT;
        int l = (k / HT) % VT;
        return (p >= HP + HB && p < HP + HB + HA && l >= VP + VB && l < VP + VB + VA) ? 1 : 0;
    endfunction

    function automatic int f_addr(int k);
        int dx = k % HT - (HP + HB);
        int dy = (k / HT) % VT - (VP + VB);
        return (dy * IH / VA) * IW + dx * IW / HA;
    endfunction

    task automatic check_dut(string n, int lat, int addr, int rd, int fs, int de, int hs,
                             int vs, int rgb);
        int k = cyc - lat - 1;
        int e_de = 0, e_hs = 1, e_vs = 1, e_fs = 0, e_rgb = 0, e_addr = 0, e_rd = 0;
        if (k >= 0) begin
            e_de  = f_de(k);
            e_hs  = (k % HT) >= HP ? 1 : 0;
            e_vs  = ((k / HT) % VT) >= VP ? 1 : 0;
            e_fs  = (k % FR) == (VP + VB) * HT + HP + HB ? 1 : 0;
            e_rgb = e_de ? int'(mem[f_addr(k)]) : 0;
        end
        if (cyc >= 1 && f_de(cyc - 1) == 1) begin
            e_rd   = 1;
            e_addr = f_addr(cyc - 1);
        end
        check({n, ".de"}, de, e_de);
        check({n, ".hsync"}, hs, e_hs);
        check({n, ".vsync"}, vs, e_vs);
        check({n, ".frame_start"}, fs, e_fs);
        check({n, ".rgb"}, rgb, e_rgb);
        check({n, ".mem_addr"}, addr, e_addr);
        check({n, ".mem_rd"}, rd, e_rd);
    endtask

    always @(negedge clk) begin
        if (valid) begin
            check_dut("a", 1, a_addr, a_rd, a_fs, a_de, a_hs, a_vs, {a_r, a_g, a_b});
            check_dut("b", 3, b_addr, b_rd, b_fs, b_de, b_hs, b_vs, {b_r, b_g, b_b});
        end
    end

    // Hand-computed expectations for the first frame after power-on reset
    int s_de = 0, s_hs = 0, s_vs = 0, s_fs = 0, s_rd = 0, s_max = 0, b_idx = 0;
    bit done = 0;
    always @(negedge clk) begin
        if (valid && cyc == 0) begin
            check("post_reset.de", b_de, 0);
            check("post_reset.hsync", b_hs, 1);
            check("post_reset.vsync", b_vs, 1);
            check("post_reset.rgb", {b_r, b_g, b_b}, 0);
        end
        if (valid && !done) begin
            if (cyc == 2) check("first_hsync_low", a_hs, 0);
            if (cyc >= 2 && cyc < 2 + FR) begin
                s_de += a_de;
                s_hs += !a_hs;
                s_vs += !a_vs;
                s_fs += a_fs;
            end
            if (cyc >= 1 && cyc < 1 + FR) begin
                s_rd += a_rd;
                if (int'(a_addr) > s_max) s_max = a_addr;
            end
            if (b_de) begin
                if (b_idx == 0) begin
                    check("lat3.first_pixel", {b_r, b_g, b_b}, mem[0]);
                    check("lat3.first_fs", b_fs, 1);
                end
                if (b_idx == 4) check("lat3.pixel4", {b_r, b_g, b_b}, mem[1]);
                b_idx++;
            end
            if (cyc == 2 + FR) begin
                check("frame.de_cycles", s_de, HA * VA);
                check("frame.hsync_low", s_hs, HP * VT);
                check("frame.vsync_low", s_vs, VP * HT);
                check("frame.fs_pulses", s_fs, 1);
                check("frame.rd_cycles", s_rd, HA * VA);
                check("frame.max_addr", s_max, 34);
                done = 1;
            end
        end
    end

    initial begin
        int guard;
        for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
        repeat (3) @(posedge clk);
        #2 rst = 0;
        repeat (3 * FR) @(posedge clk);
        #2;
        guard = 0;
        while ((cyc % FR) != 7 * HT + 10 && guard < 2 * FR) begin
            @(posedge clk);
            #2;
            guard++;
        end
        check("mid_line_reached", guard < 2 * FR ? 1 : 0, 1);
        rst = 1;
        @(posedge clk);
        #2 rst = 0;
        repeat (2 * FR) @(posedge clk);
        for (int s = 0; s < 6; s++) begin
            repeat ($urandom_range(50, 1000)) @(posedge clk);
            #2 rst = 1;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #2 rst = 0;
        end
        repeat (2 * FR) @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/lcd_scaled_timing_gen.md
Name: lcd_scaled_timing_gen

Overview:
Parametrised successor to the fixed-geometry LCD timing block. Generates HSYNC/VSYNC/DE for any panel geometry and scales a stored IMG_W x IMG_H RGB565 frame to the full active area. Scaling uses per-axis DDA accumulators, with no multipliers or dividers. The framebuffer read port has configurable latency, and the sync/DE outputs are delayed to stay pixel-aligned with the returned data. The block sits between the framebuffer BRAM (Gowin_SP or equivalent) and the LCD pins.

Parameters:
H_AREA, 800, active pixels per line
H_PULSE, 1, HSYNC low width (pixels)
H_BP, 46, pixels between pulse end and active start
H_FP, 210, pixels after active end
V_AREA, 480, active lines
V_PULSE, 4, VSYNC low width (lines)
V_BP, 20, lines between pulse end and active start
V_FP, 19, lines after active end
IMG_W, 200, source image width (1..H_AREA)
IMG_H, 138, source image height (1..V_AREA)
ADDR_W, 15, framebuffer address width; must satisfy IMG_W*IMG_H <= 2^ADDR_W
MEM_LAT, 1, framebuffer read latency in cycles (1..4)

Ports:
PixelClk  in  1  pixel clock; all logic on rising edge
RST  in  1  synchronous active-high reset
mem_addr  out  ADDR_W  framebuffer read address
mem_rd  out  1  read strobe; high for active-area addresses
mem_data  in  16  RGB565 data, valid MEM_LAT cycles after mem_addr
frame_start  out  1  one-cycle pulse, aligned with first DE of a frame
LCD_DE  out  1  data enable
LCD_HSYNC  out  1  active-low horizontal sync
LCD_VSYNC  out  1  active-low vertical sync
LCD_R  out  5  red
LCD_G  out  6  green
LCD_B  out  5  blue

Behaviour:
- Line length: H_TOT = H_PULSE+H_BP+H_AREA+H_FP.
- Frame length: V_TOT = V_PULSE+V_BP+V_AREA+V_FP.
- pcnt counts 0..H_TOT-1. lcnt increments when pcnt wraps, and wraps at V_TOT-1.
- Raw HSYNC = (pcnt >= H_PULSE). Raw VSYNC = (lcnt >= V_PULSE).
- Raw DE = (pcnt in [H_PULSE+H_BP, H_PULSE+H_BP+H_AREA)) AND (lcnt in the equivalent vertical window).
- X DDA:
  - xacc and img_x clear at the start of each active line.
  - Each active pixel adds IMG_W to xacc; if the result is >= H_AREA, subtract H_AREA and increment img_x.
  - Resulting address column = floor(dx*IMG_W/H_AREA).
- Y DDA:
  - Same rule per active line, using IMG_H/V_AREA.
  - Maintains line_base, which increases by IMG_W on each img_y step; line_base and yacc clear at frame start.
- Address stage: mem_addr = line_base + img_x, registered. mem_rd = registered raw DE. Outside the active area, mem_addr = 0.
- Clamp: img_x is never > IMG_W-1 and img_y is never > IMG_H-1; assert in simulation.
- Total latency L = MEM_LAT+1 cycles from counter to pins. Raw HSYNC/VSYNC/DE and frame_start pass through an L-deep shift register.
- RGB = mem_data split 15:11/10:5/4:0 when delayed DE = 1; otherwise 0.
- Reset (sync, dominant over all other logic):
  - pcnt=lcnt=0; accumulators, line_base and pipeline cleared.
  - mem_addr=0, mem_rd=0, LCD_DE=0, LCD_HSYNC=1, LCD_VSYNC=1, RGB=0, frame_start=0.
  - First cycle after RST release is pcnt=0, lcnt=0. The pulse appears at the pins L cycles later.
- Reset mid-frame: outputs take reset values on the next edge with no partial-pixel glitch. Timing restarts at frame origin.
- Wrap: the pcnt wrap and lcnt wrap in the same cycle restart the frame. The Y DDA step and frame clear never coincide.

Optional Feature:
LCD_TESTPAT_EN.
- Defined: adds input `pat_sel` (1 bit, sampled at frame_start only).
  - When pat_sel = 1, RGB shows 8 vertical colour bars, each H_AREA/8 wide: white, yellow, cyan, green, magenta, red, blue, black in RGB565 (FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000).
  - The bars are aligned to delayed DE, and mem_rd is forced to 0.
- Undefined: no pat_sel port; behaviour exactly as above.

Test Plan:
- Reset, then 5 cycles with MEM_LAT=1 -> HSYNC=1, VSYNC=1 at cycle 0; HSYNC=0 at cycle 2; DE=0; RGB=0.
- Defaults, count pins for one line/frame -> HSYNC period 1057 cycles, low 1 cycle; VSYNC period 523*1057, low 4 lines; DE high 800 cycles/line on 480 lines.
- First active line -> mem_addr sequence 0,0,0,0,1,1,1,1,...,199 (each repeated 4x); mem_rd high for exactly 800 cycles.
- Last active pixel of frame -> mem_addr = 27599. Active line 4 (dy=4, floor(4*138/480)=1) -> base 200. Addresses never exceed 27599.
- MEM_LAT=3, memory model returns addr as data -> first DE-high pixel RGB565 = 0x0000, pixel 4 = 0x0001. Delayed DE aligned exactly with returned data.
- Assert RST for 1 cycle mid-line 100 -> next edge: DE=0, HSYNC=1, VSYNC=1, RGB=0. Subsequent frame is identical to the post-power-on frame.
